mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 115 +++++++++++
 tb/tb_mem_arbiter.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-requester arbiter (instruction fetch and data) for one shared memory port.
// Data has priority, fetch is protected from starvation, and a stuck access is timed out.
module mem_arbiter #(
   parameter int unsigned TIMEOUT    = 16,
   parameter int unsigned STARVE_MAX = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic [31:0] if_rdata,
   output logic        if_valid,
   output logic        if_stall,
   input  logic        d_req,
   input  logic        d_rw,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   input  logic [1:0]  d_size,
   output logic [31:0] d_rdata,
   output logic        d_valid,
   output logic        d_stall,
   output logic        mem_req,
   output logic        mem_rw,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [1:0]  mem_size,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack,
   output logic        err
);

   localparam int unsigned WaitW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam int unsigned StarveW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
   localparam logic [WaitW-1:0]   WaitLast  = WaitW'(TIMEOUT - 1);
   localparam logic [StarveW-1:0] StarveLim = StarveW'(STARVE_MAX);

   typedef enum logic [1:0] {StIdle, StData, StFetch} state_e;

   state_e               state_q;
   logic [WaitW-1:0]     wait_cnt_q;
   logic [StarveW-1:0]   starve_cnt_q;

   logic busy, timed_out, done, d_done, f_done;
   logic arb_en, d_cand, f_cand, grant_d, grant_f;

   always_comb begin
      busy      = (state_q != StIdle);
      timed_out = busy & ~mem_ack & (wait_cnt_q == WaitLast);
      done      = busy & (mem_ack | timed_out);
      d_done    = (state_q == StData) & done;
      f_done    = (state_q == StFetch) & done;
      // A timed-out access always returns to idle; only an acked one may chain a grant.
      arb_en    = ~busy | mem_ack;
      d_cand    = d_req & ~d_done;
      f_cand    = if_req & ~f_done;
      grant_f   = arb_en & f_cand & (~d_cand | (starve_cnt_q == StarveLim));
      grant_d   = arb_en & d_cand & ~grant_f;
   end

   // Completion is combinational on mem_ack; a cycle in reset never completes.
   assign d_valid  = d_done & ~reset;
   assign if_valid = f_done & ~reset;
   assign d_rdata  = (d_valid & mem_ack) ? mem_rdata : 32'h0;
   assign if_rdata = (if_valid & mem_ack) ? mem_rdata : 32'h0;
   assign d_stall  = d_req & ~d_valid;
   assign if_stall = if_req & ~if_valid;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= StIdle;
         wait_cnt_q   <= '0;
         starve_cnt_q <= '0;
         mem_req      <= 1'b0;
         mem_rw       <= 1'b0;
         mem_addr     <= 32'h0;
         mem_wdata    <= 32'h0;
         mem_size     <= 2'd0;
         err          <= 1'b0;
      end else begin
         if (timed_out) begin
            err <= 1'b1;
         end

         if (!if_req || grant_f) begin
            starve_cnt_q <= '0;
         end else if (grant_d && (starve_cnt_q != StarveLim)) begin
            starve_cnt_q <= starve_cnt_q + StarveW'(1);
         end

         if (grant_d) begin
            state_q    <= StData;
            wait_cnt_q <= '0;
            mem_req    <= 1'b1;
            mem_rw     <= d_rw;
            mem_addr   <= d_addr;
            mem_wdata  <= d_wdata;
            mem_size   <= d_size;
         end else if (grant_f) begin
            state_q    <= StFetch;
            wait_cnt_q <= '0;
            mem_req    <= 1'b1;
            mem_rw     <= 1'b0;
            mem_addr   <= if_addr;
            mem_wdata  <= 32'h0;
            mem_size   <= 2'd2;
         end else if (done) begin
            state_q <= StIdle;
            mem_req <= 1'b0;
         end else if (busy) begin
            wait_cnt_q <= wait_cnt_q + WaitW'(1);
         end
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed transaction table, corner sequences, and a
// randomized run against a transaction-level reference model.
module tb_mem_arbiter;

   localparam int unsigned TO = 16;
   localparam int unsigned SM = 2;

   logic        clock = 1'b0;
   logic        reset;
   logic        if_req;
   logic [31:0] if_addr;
   logic [31:0] if_rdata;
   logic        if_valid;
   logic        if_stall;
   logic        d_req;
   logic        d_rw;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic [1:0]  d_size;
   logic [31:0] d_rdata;
   logic        d_valid;
   logic        d_stall;
   logic        mem_req;
   logic        mem_rw;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [1:0]  mem_size;
   logic [31:0] mem_rdata;
   logic        mem_ack;
   logic        err;

   always #5 clock = ~clock;

   mem_arbiter #(.TIMEOUT(TO), .STARVE_MAX(SM)) dut (
      .clock    (clock),
      .reset    (reset),
      .if_req   (if_req),
      .if_addr  (if_addr),
      .if_rdata (if_rdata),
      .if_valid (if_valid),
      .if_stall (if_stall),
      .d_req    (d_req),
      .d_rw     (d_rw),
      .d_addr   (d_addr),
      .d_wdata  (d_wdata),
      .d_size   (d_size),
      .d_rdata  (d_rdata),
      .d_valid  (d_valid),
      .d_stall  (d_stall),
      .mem_req  (mem_req),
      .mem_rw   (mem_rw),
      .mem_addr (mem_addr),
      .mem_wdata(mem_wdata),
      .mem_size (mem_size),
      .mem_rdata(mem_rdata),
      .mem_ack  (mem_ack),
      .err      (err)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         if (errors <= 40)
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      if_req = 0; if_addr = 0; d_req = 0; d_rw = 0; d_addr = 0; d_wdata = 0; d_size = 0;
      mem_ack = 0; mem_rdata = 0;
   endtask

   task automatic do_reset();
      @(posedge clock); #1;
      idle_inputs();
      reset = 1;
      @(posedge clock); #1;
      reset = 0;
   endtask

   typedef struct {
      logic        is_d;
      logic        rw;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [1:0]  size;
      int          ack_at;   // mem_req cycle carrying mem_ack, 0 = never
      logic [31:0] e_addr;
      logic        e_rw;
      logic [1:0]  e_size;
      logic [31:0] e_wdata;
      int          e_lat;    // cycle of the valid pulse, request cycle = 1
      logic        e_err;
   } vec_t;

   vec_t vecs[7];

   task automatic run_vec(input int idx, input vec_t v);
      int          cyc;
      int          nreq;
      logic        got;
      logic        vld;
      logic [31:0] exp_rd;
      logic [31:0] act_rd;
      @(posedge clock); #1;
      if (v.is_d) begin
         d_req = 1; d_rw = v.rw; d_addr = v.addr; d_wdata = v.wdata; d_size = v.size;
      end else begin
         if_req = 1; if_addr = v.addr;
      end
      cyc = 1; nreq = 0; got = 0; exp_rd = 0;
      while (!got && cyc < 40) begin
         @(posedge clock); #1;
         cyc++;
         mem_rdata = $urandom;
         mem_ack = 0;
         if (mem_req) begin
            nreq++;
            if (nreq == 1) begin
               chk($sformatf("vec%0d mem_addr", idx), mem_addr, v.e_addr);
               chk($sformatf("vec%0d mem_rw", idx), {31'b0, mem_rw}, {31'b0, v.e_rw});
               chk($sformatf("vec%0d mem_size", idx), {30'b0, mem_size}, {30'b0, v.e_size});
               if (v.e_rw) chk($sformatf("vec%0d mem_wdata", idx), mem_wdata, v.e_wdata);
            end
            if (nreq == v.ack_at) begin
               mem_ack = 1;
               exp_rd = mem_rdata;
            end
         end
         @(negedge clock);
         vld    = v.is_d ? d_valid : if_valid;
         act_rd = v.is_d ? d_rdata : if_rdata;
         if (vld) begin
            got = 1;
            chk($sformatf("vec%0d latency", idx), cyc, v.e_lat);
            chk($sformatf("vec%0d rdata", idx), act_rd, exp_rd);
         end
      end
      if (!got) chk($sformatf("vec%0d valid seen", idx), 0, 1);
      @(posedge clock); #1;
      if_req = 0; d_req = 0; mem_ack = 0;
      @(negedge clock);
      chk($sformatf("vec%0d err", idx), {31'b0, err}, {31'b0, v.e_err});
      chk($sformatf("vec%0d mem_req idle", idx), {31'b0, mem_req}, 0);
   endtask

   // Reference model state: who owns the port, how long, and the data-grant streak.
   int   m_owner;  // 0 none, 1 data, 2 fetch
   int   m_age;
   int   m_run;
   logic m_err;
   logic prev_dv, prev_iv;
   int   quiet;

   task automatic model_cycle();
      logic completes, to, e_dv, e_iv, dc, fc;
      int   g;
      chk("rnd mem_req", {31'b0, mem_req}, {31'b0, (m_owner != 0)});
      if (m_owner == 1) begin
         chk("rnd d addr", mem_addr, d_addr);
         chk("rnd d rw", {31'b0, mem_rw}, {31'b0, d_rw});
         chk("rnd d size", {30'b0, mem_size}, {30'b0, d_size});
         if (d_rw) chk("rnd d wdata", mem_wdata, d_wdata);
      end else if (m_owner == 2) begin
         chk("rnd f addr", mem_addr, if_addr);
         chk("rnd f rw", {31'b0, mem_rw}, 0);
         chk("rnd f size", {30'b0, mem_size}, 2);
      end
      completes = (m_owner != 0) && (mem_ack || m_age == TO - 1);
      to        = (m_owner != 0) && !mem_ack && m_age == TO - 1;
      e_dv      = (m_owner == 1) && completes;
      e_iv      = (m_owner == 2) && completes;
      chk("rnd d_valid", {31'b0, d_valid}, {31'b0, e_dv});
      chk("rnd if_valid", {31'b0, if_valid}, {31'b0, e_iv});
      if (e_dv) chk("rnd d_rdata", d_rdata, mem_ack ? mem_rdata : 32'h0);
      if (e_iv) chk("rnd if_rdata", if_rdata, mem_ack ? mem_rdata : 32'h0);
      chk("rnd d_stall", {31'b0, d_stall}, {31'b0, d_req && !e_dv});
      chk("rnd if_stall", {31'b0, if_stall}, {31'b0, if_req && !e_iv});
      chk("rnd err", {31'b0, err}, {31'b0, m_err});

      g = 0;
      if (m_owner == 0 || (completes && !to)) begin
         dc = d_req && (m_owner != 1);
         fc = if_req && (m_owner != 2);
         if (fc && (!dc || m_run == SM)) g = 2;
         else if (dc) g = 1;
      end
      if (!if_req || g == 2) m_run = 0;
      else if (g == 1 && m_run < SM) m_run++;
      if (m_owner != 0 && !completes) m_age++;
      else begin
         m_owner = g;
         m_age = 0;
      end
      if (to) m_err = 1;
      prev_dv = e_dv;
      prev_iv = e_iv;
   endtask

   logic        exp_is_d[6];
   int          grants[6];
   int          ng;
   int          n;
   logic        prev_mreq;
   logic [31:0] rd;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
      $fatal(1);
   end

   initial begin
      vecs[0] = '{1'b0, 1'b0, 32'h1000, 32'h0, 2'd0, 1,
                  32'h1000, 1'b0, 2'd2, 32'h0, 2, 1'b0};
      vecs[1] = '{1'b1, 1'b0, 32'h2004, 32'h1111_2222, 2'd0, 3,
                  32'h2004, 1'b0, 2'd0, 32'h1111_2222, 4, 1'b0};
      vecs[2] = '{1'b1, 1'b1, 32'h3002, 32'h1234_ABCD, 2'd1, 1,
                  32'h3002, 1'b1, 2'd1, 32'h1234_ABCD, 2, 1'b0};
      vecs[3] = '{1'b0, 1'b0, 32'h0000_0040, 32'h0, 2'd0, 5,
                  32'h0000_0040, 1'b0, 2'd2, 32'h0, 6, 1'b0};
      vecs[4] = '{1'b1, 1'b1, 32'hFFFF_FFFC, 32'hCAFE_F00D, 2'd2, 16,
                  32'hFFFF_FFFC, 1'b1, 2'd2, 32'hCAFE_F00D, 17, 1'b0};
      vecs[5] = '{1'b1, 1'b0, 32'h0000_0044, 32'h0, 2'd2, 0,
                  32'h0000_0044, 1'b0, 2'd2, 32'h0, 17, 1'b1};
      vecs[6] = '{1'b0, 1'b0, 32'h0000_0080, 32'h0, 2'd0, 2,
                  32'h0000_0080, 1'b0, 2'd2, 32'h0, 3, 1'b1};
      exp_is_d = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

      // Reset state
      idle_inputs();
      reset = 1;
      @(posedge clock);
      @(posedge clock);
      @(negedge clock);
      chk("rst mem_req", {31'b0, mem_req}, 0);
      chk("rst mem_rw", {31'b0, mem_rw}, 0);
      chk("rst mem_addr", mem_addr, 0);
      chk("rst mem_wdata", mem_wdata, 0);
      chk("rst mem_size", {30'b0, mem_size}, 0);
      chk("rst err", {31'b0, err}, 0);
      chk("rst valids", {30'b0, if_valid, d_valid}, 0);
      @(posedge clock); #1;
      reset = 0;

      for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);
      @(negedge clock);
      chk("err sticky", {31'b0, err}, 1);
      do_reset();
      @(negedge clock);
      chk("err cleared by reset", {31'b0, err}, 0);

      // Simultaneous requests: data first, fetch chained with no idle cycle
      @(posedge clock); #1;
      if_req = 1; if_addr = 32'h5000;
      d_req = 1; d_rw = 1; d_addr = 32'h2000; d_wdata = 32'hDEAD_BEEF; d_size = 2;
      @(posedge clock); #1;
      chk("both mem_req", {31'b0, mem_req}, 1);
      chk("both d addr", mem_addr, 32'h2000);
      chk("both d rw", {31'b0, mem_rw}, 1);
      chk("both d wdata", mem_wdata, 32'hDEAD_BEEF);
      mem_ack = 1;
      @(negedge clock);
      chk("both d_valid", {31'b0, d_valid}, 1);
      chk("both if_stall", {31'b0, if_stall}, 1);
      chk("both d_stall", {31'b0, d_stall}, 0);
      chk("both if_valid early", {31'b0, if_valid}, 0);
      @(posedge clock); #1;
      d_req = 0;
      rd = $urandom;
      mem_rdata = rd;
      chk("chain mem_req", {31'b0, mem_req}, 1);
      chk("chain f addr", mem_addr, 32'h5000);
      chk("chain f rw", {31'b0, mem_rw}, 0);
      chk("chain f size", {30'b0, mem_size}, 2);
      @(negedge clock);
      chk("chain if_valid", {31'b0, if_valid}, 1);
      chk("chain if_rdata", if_rdata, rd);
      @(posedge clock); #1;
      if_req = 0; mem_ack = 0;
      @(negedge clock);
      chk("chain idle", {31'b0, mem_req}, 0);

      // Starvation guard, observed through timed-out accesses that return to idle
      do_reset();
      d_req = 1; d_rw = 0; d_addr = 32'hA0; d_size = 2;
      if_req = 1; if_addr = 32'hB0;
      ng = 0;
      prev_mreq = 0;
      for (int c = 0; c < 150 && ng < 6; c++) begin
         @(posedge clock); #1;
         if (mem_req && !prev_mreq) begin
            grants[ng] = (mem_addr == 32'hA0) ? 1 : 0;
            ng++;
         end
         prev_mreq = mem_req;
      end
      for (int i = 0; i < 6; i++) begin
         chk($sformatf("starve grant%0d is_data", i), (i < ng) ? grants[i] : 2,
             {31'b0, exp_is_d[i]});
      end
      chk("starve err", {31'b0, err}, 1);

      // Reset in the middle of a read, then a stray ack
      do_reset();
      d_req = 1; d_rw = 0; d_addr = 32'h300; d_size = 2;
      n = 0;
      for (int c = 0; c < 20 && n < 3; c++) begin
         @(posedge clock); #1;
         if (mem_req) n++;
      end
      chk("midrst reached 3rd wait", n, 3);
      reset = 1;
      d_req = 0;
      @(negedge clock);
      chk("midrst d_valid", {31'b0, d_valid}, 0);
      @(posedge clock); #1;
      reset = 0;
      @(negedge clock);
      chk("midrst mem_req", {31'b0, mem_req}, 0);
      chk("midrst err", {31'b0, err}, 0);
      for (int c = 0; c < 3; c++) begin
         @(posedge clock); #1;
         mem_ack = 1;
         mem_rdata = $urandom;
         @(negedge clock);
         chk("stray ack valids", {30'b0, if_valid, d_valid}, 0);
         chk("stray ack mem_req", {31'b0, mem_req}, 0);
      end

      // Randomized traffic against the reference model
      do_reset();
      m_owner = 0; m_age = 0; m_run = 0; m_err = 0;
      prev_dv = 0; prev_iv = 0; quiet = 0;
      for (int c = 0; c < 3000; c++) begin
         @(posedge clock); #1;
         if (d_req && prev_dv) begin
            if ($urandom_range(0, 1) == 1) begin
               d_rw = 1'($urandom_range(0, 1)); d_addr = $urandom; d_wdata = $urandom;
               d_size = 2'($urandom_range(0, 2));
            end else d_req = 0;
         end else if (!d_req && $urandom_range(0, 2) == 0) begin
            d_req = 1;
            d_rw = 1'($urandom_range(0, 1)); d_addr = $urandom; d_wdata = $urandom;
            d_size = 2'($urandom_range(0, 2));
         end
         if (if_req && prev_iv) begin
            if ($urandom_range(0, 1) == 1) if_addr = $urandom;
            else if_req = 0;
         end else if (!if_req && $urandom_range(0, 2) == 0) begin
            if_req = 1;
            if_addr = $urandom;
         end
         mem_rdata = $urandom;
         if (quiet > 0) begin
            quiet--;
            mem_ack = 0;
         end else begin
            if ($urandom_range(0, 99) == 0) quiet = 20;
            mem_ack = mem_req ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 9) == 0);
         end
         @(negedge clock);
         model_cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
